// File: rtl/sha3_digest_serializer.sv
// sha3_digest_serializer: captures the digest lanes of a final Keccak state and
// streams them out as 32-bit words, low half of each lane first.
module sha3_digest_serializer #(
  parameter int DIGEST_BITS = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  input  logic             sample,
  output logic             iready,
  output logic [31:0]      odata,
  output logic             ovalid,
  input  logic             oready,
  output logic             olast,
  output logic             ooverrun
);
  localparam int WORDS = DIGEST_BITS / 32;
  localparam int LANES = (WORDS + 1) / 2;
  localparam logic [3:0] LAST = 4'(WORDS - 1);
  if (DIGEST_BITS != 224 && DIGEST_BITS != 256 && DIGEST_BITS != 384 && DIGEST_BITS != 512) begin : g_bad_digest
    $error("sha3_digest_serializer: DIGEST_BITS must be 224, 256, 384 or 512");
  end
  typedef enum logic {IDLE, EMIT} state_t;
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0][63:0] lane_q, lane_d;
  logic ovr_q, ovr_d;
  logic [7:0][63:0] in_lanes;
  logic cap;
  logic unused_in;
  // Squeeze order: the five lanes of row a, then the first lanes of row b.
  assign in_lanes = {isb[2:0], isa};
  assign unused_in = ^{in_lanes, isb[4:3], isc, isd, ise};
  assign ooverrun = ovr_q;
  always_comb begin
    ovalid = state_q == EMIT;
    olast = ovalid && idx_q == LAST;
    iready = !ovalid || (olast && oready);
    odata = !ovalid ? '0 : idx_q[0] ? lane_q[idx_q[3:1]][63:32] : lane_q[idx_q[3:1]][31:0];
    cap = sample && iready;
    state_d = cap ? EMIT : (olast && oready) ? IDLE : state_q;
    idx_d = (cap || (olast && oready)) ? 4'd0 : (ovalid && oready) ? idx_q + 4'd1 : idx_q;
    ovr_d = sample && !iready;
    lane_d = lane_q;
    for (int l = 0; l < LANES; l++) lane_d[l] = cap ? in_lanes[l] : lane_q[l];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q <= '0;
      lane_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      lane_q <= lane_d;
      ovr_q <= ovr_d;
    end
  end
endmodule

// File: tb/tb_sha3_digest_serializer.sv
// tb_sha3_digest_serializer: four digest sizes side by side, each checked every
// cycle against a word-queue model of the expected output stream.
module tb_sha3_digest_serializer;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [4:0][63:0] isa, isb, isc, isd, ise;
  logic smp [4];
  logic ord [4];
  logic irdy [4];
  logic [31:0] od [4];
  logic ovl [4];
  logic ol [4];
  logic ovr [4];
  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] qd [4][64];
  int qh [4];
  int qt [4];
  logic ov [4];
  logic [32:0] logd [4][1024];
  int logn [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DB = (g == 0) ? 224 : (g == 1) ? 256 : (g == 2) ? 384 : 512;
    sha3_digest_serializer #(.DIGEST_BITS(DB)) u_dut (
      .clk(clk), .rstn(rstn), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
      .sample(smp[g]), .iready(irdy[g]), .odata(od[g]), .ovalid(ovl[g]),
      .oready(ord[g]), .olast(ol[g]), .ooverrun(ovr[g])
    );
  end

  function automatic int nwords(input int i);
    return (i == 0) ? 7 : (i == 1) ? 8 : (i == 2) ? 12 : 16;
  endfunction

  function automatic logic [31:0] wd(input logic [639:0] f, input int k);
    return f[32*k +: 32];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each accepted sample appends its digest words to a queue;
  // the head of the queue is what must be on odata while ovalid is high.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int n;
      logic ir;
      logic [639:0] flat;
      if (!rstn) begin
        qh[i] = qt[i];
        ov[i] = 1'b0;
      end
      n = qt[i] - qh[i];
      ir = (n == 0) || (n == 1 && ord[i]);
      check("ovalid", 64'(ovl[i]), 64'(n != 0));
      check("odata", 64'(od[i]), n != 0 ? 64'(qd[i][qh[i] % 64][31:0]) : 64'd0);
      check("olast", 64'(ol[i]), n != 0 ? 64'(qd[i][qh[i] % 64][32]) : 64'd0);
      check("iready", 64'(irdy[i]), 64'(ir));
      check("ooverrun", 64'(ovr[i]), 64'(ov[i]));
      if (rstn) begin
        if (ovl[i] && ord[i]) begin
          logd[i][logn[i] % 1024] = {ol[i], od[i]};
          logn[i]++;
        end
        if (n != 0 && ord[i]) qh[i]++;
        ov[i] = smp[i] && !ir;
        if (smp[i] && ir) begin
          flat = {isb, isa};
          for (int k = 0; k < nwords(i); k++) begin
            qd[i][qt[i] % 64] = {k == nwords(i) - 1, wd(flat, k)};
            qt[i]++;
          end
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < 5; l++) begin
      isa[l] = {$urandom, $urandom};
      isb[l] = {$urandom, $urandom};
      isc[l] = {$urandom, $urandom};
      isd[l] = {$urandom, $urandom};
      ise[l] = {$urandom, $urandom};
    end
  endtask

  task automatic fire(input int i);
    smp[i] = 1'b1;
    step();
    smp[i] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t1 [8];
    logic [639:0] f;
    int lb;
    logic found;
    t1 = '{32'h89ABCDEF, 32'h01234567, 32'h22222222, 32'h11111111,
           32'h0, 32'h0, 32'h00000000, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      smp[i] = 1'b0;
      ord[i] = 1'b1;
    end
    rand_lanes();
    #1 rstn = 1'b0;
    step(2);
    check("rst_iready", 64'(irdy[1]), 64'd1);
    check("rst_ovalid", 64'(ovl[1]), 64'd0);
    check("rst_odata", 64'(od[1]), 64'd0);
    rstn = 1'b1;

    // Single 256-bit digest with fixed lanes
    isa = '0;
    isa[0] = 64'h0123456789ABCDEF;
    isa[1] = 64'h1111111122222222;
    isa[3] = 64'hFFFFFFFF00000000;
    lb = logn[1];
    fire(1);
    step(12);
    check("t1_count", 64'(logn[1] - lb), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check("t1_word", 64'(logd[1][(lb + k) % 1024][31:0]), 64'(t1[k]));
      check("t1_last", 64'(logd[1][(lb + k) % 1024][32]), 64'(k == 7));
    end
    check("t1_idle_iready", 64'(irdy[1]), 64'd1);

    // Backpressure on word 2
    rand_lanes();
    f = {isb, isa};
    lb = logn[1];
    fire(1);
    step(2);
    ord[1] = 1'b0;
    step(5);
    check("t2_hold", 64'(od[1]), 64'(wd(f, 2)));
    ord[1] = 1'b1;
    step(10);
    check("t2_count", 64'(logn[1] - lb), 64'd8);
    for (int k = 0; k < 8; k++) check("t2_word", 64'(logd[1][(lb + k) % 1024][31:0]), 64'(wd(f, k)));

    // Overrun while word 3 is pending
    rand_lanes();
    f = {isb, isa};
    lb = logn[1];
    fire(1);
    step(3);
    ord[1] = 1'b0;
    isa[0] = 64'hDEAD;
    fire(1);
    check("t3_ovr_pulse", 64'(ovr[1]), 64'd1);
    step();
    check("t3_ovr_clear", 64'(ovr[1]), 64'd0);
    ord[1] = 1'b1;
    step(10);
    check("t3_count", 64'(logn[1] - lb), 64'd8);
    for (int k = 0; k < 8; k++) check("t3_word", 64'(logd[1][(lb + k) % 1024][31:0]), 64'(wd(f, k)));

    // Back-to-back on the olast handshake
    rand_lanes();
    fire(1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (ovl[1] && ol[1]) found = 1'b1;
      else step();
    end
    check("t4_olast_seen", 64'(found), 64'd1);
    rand_lanes();
    f = {isb, isa};
    fire(1);
    check("t4_ovalid", 64'(ovl[1]), 64'd1);
    check("t4_word0", 64'(od[1]), 64'(wd(f, 0)));
    check("t4_no_ovr", 64'(ovr[1]), 64'd0);
    step(12);

    // Other digest sizes
    for (int i = 0; i < 4; i += (i == 0) ? 2 : 1) begin
      logic [31:0] lw;
      rand_lanes();
      lw = (i == 0) ? isa[3][31:0] : (i == 2) ? isb[0][63:32] : isb[2][63:32];
      lb = logn[i];
      fire(i);
      step(20);
      check("t5_count", 64'(logn[i] - lb), 64'(nwords(i)));
      check("t5_last_word", 64'(logd[i][(lb + nwords(i) - 1) % 1024][31:0]), 64'(lw));
      check("t5_last_flag", 64'(logd[i][(lb + nwords(i) - 1) % 1024][32]), 64'd1);
      if (i == 3) check("t5_penult", 64'(logd[i][(lb + 14) % 1024][31:0]), 64'(isb[2][31:0]));
    end

    // Random traffic on all four sizes
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        ord[i] = $urandom_range(0, 3) != 0;
        smp[i] = $urandom_range(0, 7) == 0;
      end
      rand_lanes();
      step();
    end
    for (int i = 0; i < 4; i++) begin
      smp[i] = 1'b0;
      ord[i] = 1'b1;
    end
    step(20);

    // Reset during word 4
    rand_lanes();
    fire(1);
    step(4);
    #2 rstn = 1'b0;
    #1;
    check("t6_ovalid", 64'(ovl[1]), 64'd0);
    check("t6_odata", 64'(od[1]), 64'd0);
    check("t6_iready", 64'(irdy[1]), 64'd1);
    step(2);
    rstn = 1'b1;
    step(3);
    check("t6_quiet", 64'(ovl[1]), 64'd0);
    rand_lanes();
    f = {isb, isa};
    fire(1);
    check("t6_restart_valid", 64'(ovl[1]), 64'd1);
    check("t6_restart_word0", 64'(od[1]), 64'(wd(f, 0)));
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sha3_digest_serializer.md
Name: sha3_digest_serializer

Overview:
- Consumer end of the final-round state path: accepts the 25-lane Keccak state on a one-cycle `sample` strobe, which is the `ogood` of the last-round/finalizer stage.
- Captures only the digest lanes and streams the digest out as 32-bit words over a valid/ready handshake.
- Sits between the hashing core and the host/readback logic, and frees the core as soon as the state is captured.

Parameters:
- DIGEST_BITS, 256, digest length; legal values 224, 256, 384, 512; anything else is an elaboration error.
- WORDS, DIGEST_BITS/32 (derived, not overridable), word count per digest: 7, 8, 12 or 16.

Ports:
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  asynchronous, active-low reset
- isa, isb, isc, isd, ise  input  64 x5 each  state rows, same lane ordering as the core's state arrays
- sample  input  1  one-cycle strobe, state inputs valid this cycle
- iready  output  1  block can accept a sample this cycle (combinational)
- odata  output  32  digest word
- ovalid  output  1  odata valid
- oready  input  1  downstream accepts odata
- olast  output  1  high with the final word of a digest
- ooverrun  output  1  one-cycle pulse when a sample is dropped

Behaviour:
- Lane order is the FIPS 202 squeeze order: isa[0..4], then isb[0..4].
  - 224/256 use isa[0..3]; 384 uses isa[0..4] and isb[0]; 512 uses isa[0..4] and isb[0..2].
  - Only these (at most 8) lanes are registered; the remaining inputs are unused.
- Word k = lane[k/2] bits [32*(k%2) +: 32], i.e. low half first, with no byte swapping.
  - For 224, the digest ends after the low half of lane 3 (word 6).
- State machine has two states, IDLE and EMIT, with a word index `idx` of 4 bits.
- iready = (state==IDLE) | (state==EMIT & olast & oready).
- IDLE:
  - ovalid=0.
  - sample: capture the lanes, idx<=0, go to EMIT.
  - ovalid rises the cycle after the sample, so latency is 1 cycle.
- EMIT:
  - ovalid=1; odata = word[idx], driven from registers with no combinational path from the state inputs.
  - Handshake is ovalid & oready; on it, idx<=idx+1.
  - olast = (idx==WORDS-1).
  - Handshake on the last word without a sample: go to IDLE, idx<=0.
- Handshake on the last word with a simultaneous sample:
  - Recapture the new lanes, idx<=0, stay in EMIT.
  - This gives zero-bubble back-to-back digests.
- ovalid/odata stability: while ovalid=1 and oready=0, odata, olast and idx hold and must not change.
- Dropped sample: a sample while iready=0 is ignored, leaving buffer, idx and stream untouched, and ooverrun pulses high for exactly the next cycle.
- Reset values: state=IDLE, idx=0, ovalid=0, olast=0, odata=0, ooverrun=0, lane buffer=0, iready=1.
- Reset mid-digest: asserting rstn=0 while in EMIT drops ovalid immediately (asynchronous). The partial digest is discarded and no words resume after release.
- First edge after rstn deasserts: a sample is accepted normally.

Test Plan:
1. Single digest with DIGEST_BITS=256:
   - Stimulus: isa[0]=64'h0123456789ABCDEF, isa[1]=64'h1111111122222222, isa[2]=0, isa[3]=64'hFFFFFFFF00000000; sample at cycle t; oready=1.
   - Required: ovalid from t+1 for 8 cycles, odata = 89ABCDEF, 01234567, 22222222, 11111111, 0, 0, 00000000, FFFFFFFF, with olast only on the 8th word; then ovalid=0 and iready=1.
2. Backpressure:
   - Stimulus: oready=0 for 5 cycles after word 2 appears.
   - Required: word 2 is held stable all 5 cycles, then the sequence continues unchanged; total words = 8.
3. Overrun:
   - Stimulus: a second sample with isa[0]=64'hDEAD while word 3 is pending.
   - Required: ooverrun pulses 1 cycle, and the remaining words still come from the first state.
4. Back-to-back:
   - Stimulus: a second sample in the same cycle as the olast handshake, with oready=1.
   - Required: the next cycle shows word 0 of the new state with ovalid continuously high and no ooverrun.
5. Parameter sweep:
   - DIGEST_BITS=224 gives 7 words, the last being isa[3][31:0].
   - DIGEST_BITS=512 gives 16 words, the last two being isb[2] low then high.
   - DIGEST_BITS=384 gives 12 words ending with isb[0].
6. Reset mid-stream:
   - Stimulus: rstn=0 during word 4, held 2 cycles.
   - Required: ovalid=0, odata=0 and iready=1 asynchronously; after release no words appear until a new sample, which then produces word 0 at the next cycle.
